// File: rtl/median_pkg.sv
// Shared definitions for the median filter front end: defaults, window
// indexing and the frame state type.
package median_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int WIN_SIZE       = 9;
  localparam int WIN_CENTER     = 4;

  typedef enum logic {
    FRAME_IDLE   = 1'b0,
    FRAME_ACTIVE = 1'b1
  } frameState_e;

  // Flat index of window element (r,c), row-major with r=0 the oldest row.
  function automatic int winIdx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage, read-before-write at a single address so the
// previous line's pixel comes out while the current line's pixel goes in.
module line_buffer
  import median_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/median_window_3x3.sv
// Raster-stream 3x3 window generator: two line buffers feed a 3x3 register
// window that is flagged valid only for fully interior neighbourhoods.
module median_window_3x3
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic [WIN_SIZE*DATA_WIDTH-1:0] window_o,
  output logic                         valid_o,
  output logic                         done_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  frameState_e      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, colBase;
  logic [ROW_W-1:0] row_q, row_d, rowBase;
  pix_t             win_q [3][3];
  pix_t             win_d [3][3];
  pix_t             winBase [3][3];
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             accept;
  pix_t             lb1Rd, lb2Rd;
  pix_t             newMid, newTop;

  // A start pulse restarts the frame in the same cycle, so a coincident
  // pixel is taken as (0,0) against cleared counters and window.
  always_comb begin
    accept  = valid_i && (start_i || (state_q == FRAME_ACTIVE));
    colBase = start_i ? '0 : col_q;
    rowBase = start_i ? '0 : row_q;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        winBase[r][c] = start_i ? '0 : win_q[r][c];
      end
    end
  end

  line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .WIDTH  (DATA_WIDTH),
    .ADDR_W (COL_W)
  ) u_lineBuf1 (
    .clk     (clk),
    .en_i    (accept),
    .addr_i  (colBase),
    .wdata_i (data_i),
    .rdata_o (lb1Rd)
  );

  line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .WIDTH  (DATA_WIDTH),
    .ADDR_W (COL_W)
  ) u_lineBuf2 (
    .clk     (clk),
    .en_i    (accept),
    .addr_i  (colBase),
    .wdata_i (lb1Rd),
    .rdata_o (lb2Rd)
  );

  // Line buffers hold leftovers from earlier frames until this frame has
  // written them, so their outputs are masked until they carry real rows.
  assign newMid = (rowBase >= ROW_W'(1)) ? lb1Rd : '0;
  assign newTop = (rowBase >= ROW_W'(2)) ? lb2Rd : '0;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_d[r][c] = winBase[r][c];
      end
    end

    if (start_i) begin
      state_d = FRAME_ACTIVE;
      col_d   = '0;
      row_d   = '0;
    end

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = winBase[r][1];
        win_d[r][1] = winBase[r][2];
      end
      win_d[2][2] = data_i;
      win_d[1][2] = newMid;
      win_d[0][2] = newTop;

      valid_d = (rowBase >= ROW_W'(2)) && (colBase >= COL_W'(2));

      if (colBase == COL_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        if (rowBase == ROW_W'(IMG_HEIGHT - 1)) begin
          row_d   = '0;
          done_d  = 1'b1;
          state_d = FRAME_IDLE;
        end else begin
          row_d = rowBase + ROW_W'(1);
        end
      end else begin
        col_d = colBase + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FRAME_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  always_comb begin
    window_o = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        window_o[DATA_WIDTH*winIdx(r, c) +: DATA_WIDTH] = win_q[r][c];
      end
    end
  end

  assign valid_o = valid_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_median_window_3x3.sv
// Bench for median_window_3x3 on a 4x4 image: scenario tasks compare the DUT
// against a frame-array reference model of interior 3x3 neighbourhoods.
module tb_median_window_3x3;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [9*DW-1:0] window_o;
  logic          valid_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]   img [IH][IW];
  bit              mActive = 1'b0;
  int              mCount = 0;
  logic            expValid = 1'b0;
  logic            expDone = 1'b0;
  logic [9*DW-1:0] expWin = '0;

  always #5 clk = ~clk;

  median_window_3x3 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .window_o (window_o),
    .valid_o  (valid_o),
    .done_o   (done_o)
  );

  function automatic logic [9*DW-1:0] packWin(input int v[9]);
    logic [9*DW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[DW*k +: DW] = DW'(v[k]);
    return w;
  endfunction

  task automatic modelReset();
    mActive  = 1'b0;
    mCount   = 0;
    expValid = 1'b0;
    expDone  = 1'b0;
  endtask

  // Drives one clock of stimulus and advances the reference model; outputs are
  // sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic s, input logic v, input logic [DW-1:0] d);
    int r, c;
    @(negedge clk);
    start_i = s;
    valid_i = v;
    data_i  = d;
    if (s) begin
      mActive = 1'b1;
      mCount  = 0;
    end
    expValid = 1'b0;
    expDone  = 1'b0;
    if (v && mActive) begin
      r = mCount / IW;
      c = mCount % IW;
      img[r][c] = d;
      mCount++;
      if (r >= 2 && c >= 2) begin
        expValid = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            expWin[DW*(3*i+j) +: DW] = img[r-2+i][c-2+j];
      end
      if (mCount == IW * IH) begin
        expDone = 1'b1;
        mActive = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (window_o !== '0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got win=%h valid=%b done=%b, want all zero", window_o, valid_o, done_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(1'b0, 1'b1, 8'hAA);
    checks++;
    if (valid_o !== 1'b0 || window_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_no_start: got valid=%b win=%h, want valid=0 win=0", valid_o, window_o);
    end
  endtask

  task automatic test_basic_frame();
    int nWin = 0;
    int firstIdx = -1;
    logic [DW-1:0] centres[$];
    logic [9*DW-1:0] firstGot = '0;
    logic [9*DW-1:0] lastGot = '0;
    logic lastDone = 1'b0;
    int v1[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int v2[9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    int expC[4] = '{6, 7, 10, 11};
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, DW'(i + 1));
      checks++;
      if (valid_o !== expValid || done_o !== expDone) begin
        errors++;
        $display("[TB] FAIL basic_flags px %0d: got valid=%b done=%b, want valid=%b done=%b", i + 1, valid_o, done_o, expValid, expDone);
      end
      if (expValid) begin
        checks++;
        if (window_o !== expWin) begin
          errors++;
          $display("[TB] FAIL basic_window px %0d: got %h, want %h", i + 1, window_o, expWin);
        end
      end
      if (valid_o === 1'b1) begin
        nWin++;
        centres.push_back(window_o[DW*4 +: DW]);
        if (nWin == 1) begin
          firstGot = window_o;
          firstIdx = i;
        end
        lastGot  = window_o;
        lastDone = done_o;
      end
    end
    checks++;
    if (nWin != 4 || firstIdx != 10) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d windows first after px %0d, want 4 first after px 11", nWin, firstIdx + 1);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= centres.size() || centres[k] !== DW'(expC[k])) begin
        errors++;
        $display("[TB] FAIL basic_centre %0d: got %0d, want %0d", k, (k < centres.size()) ? centres[k] : 8'h0, expC[k]);
      end
    end
    checks++;
    if (firstGot !== packWin(v1)) begin
      errors++;
      $display("[TB] FAIL basic_first: got %h, want %h", firstGot, packWin(v1));
    end
    checks++;
    if (lastGot !== packWin(v2) || lastDone !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_last: got %h done=%b, want %h done=1", lastGot, lastDone, packWin(v2));
    end
  endtask

  task automatic test_gaps();
    int nWin = 0;
    logic prevValid = 1'b0;
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < 3; g++) begin
        applyStimulus(1'b0, g == 0, (g == 0) ? DW'(i + 1) : DW'(0));
        checks++;
        if (valid_o !== expValid || done_o !== expDone) begin
          errors++;
          $display("[TB] FAIL gaps_flags px %0d slot %0d: got valid=%b done=%b, want valid=%b done=%b", i + 1, g, valid_o, done_o, expValid, expDone);
        end
        if (expValid) begin
          checks++;
          if (window_o !== expWin) begin
            errors++;
            $display("[TB] FAIL gaps_window px %0d: got %h, want %h", i + 1, window_o, expWin);
          end
        end
        checks++;
        if (valid_o === 1'b1 && prevValid === 1'b1) begin
          errors++;
          $display("[TB] FAIL gaps_b2b px %0d: got valid high 2 cycles, want isolated pulses", i + 1);
        end
        prevValid = valid_o;
        if (valid_o === 1'b1) nWin++;
      end
    end
    checks++;
    if (nWin != 4) begin
      errors++;
      $display("[TB] FAIL gaps_count: got %0d windows, want 4", nWin);
    end
  endtask

  task automatic test_after_done();
    int nWin = 0;
    logic [9*DW-1:0] firstGot = '0;
    int v1[9] = '{101, 102, 103, 105, 106, 107, 109, 110, 111};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, DW'(17 + i));
      checks++;
      if (valid_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_ignore px %0d: got valid=%b done=%b, want 0 0", 17 + i, valid_o, done_o);
      end
    end
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, DW'(101 + i));
      checks++;
      if (valid_o !== expValid || done_o !== expDone) begin
        errors++;
        $display("[TB] FAIL restart_flags px %0d: got valid=%b done=%b, want valid=%b done=%b", 101 + i, valid_o, done_o, expValid, expDone);
      end
      if (expValid) begin
        checks++;
        if (window_o !== expWin) begin
          errors++;
          $display("[TB] FAIL restart_window px %0d: got %h, want %h", 101 + i, window_o, expWin);
        end
      end
      if (valid_o === 1'b1) begin
        nWin++;
        if (nWin == 1) firstGot = window_o;
      end
    end
    checks++;
    if (nWin != 4 || firstGot !== packWin(v1)) begin
      errors++;
      $display("[TB] FAIL restart_first: got %0d windows first %h, want 4 first %h", nWin, firstGot, packWin(v1));
    end
  endtask

  task automatic test_reset_midframe();
    int nWin = 0;
    logic [9*DW-1:0] firstGot = '0;
    int v1[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, DW'(i + 1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (window_o !== '0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got win=%h valid=%b done=%b, want all zero", window_o, valid_o, done_o);
    end
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (window_o !== '0 || valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_hold: got win=%h valid=%b, want zero", window_o, valid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h55);
    checks++;
    if (window_o !== '0 || valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_needs_start: got win=%h valid=%b, want zero", window_o, valid_o);
    end
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, DW'(i + 1));
      checks++;
      if (valid_o !== expValid || done_o !== expDone) begin
        errors++;
        $display("[TB] FAIL midreset_flags px %0d: got valid=%b done=%b, want valid=%b done=%b", i + 1, valid_o, done_o, expValid, expDone);
      end
      if (expValid) begin
        checks++;
        if (window_o !== expWin) begin
          errors++;
          $display("[TB] FAIL midreset_window px %0d: got %h, want %h", i + 1, window_o, expWin);
        end
      end
      if (valid_o === 1'b1) begin
        nWin++;
        if (nWin == 1) firstGot = window_o;
      end
    end
    checks++;
    if (nWin != 4 || firstGot !== packWin(v1)) begin
      errors++;
      $display("[TB] FAIL midreset_first: got %0d windows first %h, want 4 first %h", nWin, firstGot, packWin(v1));
    end
  endtask

  task automatic test_start_with_valid();
    int nWin = 0;
    int nDone = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i == 0, 1'b1, DW'(i + 1));
      checks++;
      if (valid_o !== expValid || done_o !== expDone) begin
        errors++;
        $display("[TB] FAIL startvalid_flags px %0d: got valid=%b done=%b, want valid=%b done=%b", i + 1, valid_o, done_o, expValid, expDone);
      end
      if (expValid) begin
        checks++;
        if (window_o !== expWin) begin
          errors++;
          $display("[TB] FAIL startvalid_window px %0d: got %h, want %h", i + 1, window_o, expWin);
        end
      end
      if (valid_o === 1'b1) nWin++;
      if (done_o === 1'b1) nDone++;
    end
    checks++;
    if (nWin != 4 || nDone != 1) begin
      errors++;
      $display("[TB] FAIL startvalid_count: got %0d windows %0d done, want 4 and 1", nWin, nDone);
    end
  endtask

  task automatic test_abort();
    int nWin = 0;
    int nDone = 0;
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, DW'(i + 1));
      if (done_o === 1'b1) nDone++;
    end
    applyStimulus(1'b1, 1'b0, '0);
    checks++;
    if (valid_o !== 1'b0 || done_o !== 1'b0 || nDone != 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got valid=%b done=%b earlier done=%0d, want 0 0 0", valid_o, done_o, nDone);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, DW'(31 + i));
      checks++;
      if (valid_o !== expValid || done_o !== expDone) begin
        errors++;
        $display("[TB] FAIL abort_flags px %0d: got valid=%b done=%b, want valid=%b done=%b", 31 + i, valid_o, done_o, expValid, expDone);
      end
      if (expValid) begin
        checks++;
        if (window_o !== expWin) begin
          errors++;
          $display("[TB] FAIL abort_window px %0d: got %h, want %h", 31 + i, window_o, expWin);
        end
      end
      if (valid_o === 1'b1) nWin++;
    end
    checks++;
    if (nWin != 4) begin
      errors++;
      $display("[TB] FAIL abort_count: got %0d windows, want 4", nWin);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      int nWin = 0;
      int nDone = 0;
      bit coincide;
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b1, DW'($urandom));
      coincide = $urandom_range(0, 1) == 1;
      applyStimulus(1'b1, coincide, DW'($urandom));
      if (valid_o === 1'b1) nWin++;
      for (int k = 0; k < 200 && mActive; k++) begin
        applyStimulus(1'b0, $urandom_range(0, 2) != 0, DW'($urandom));
        checks++;
        if (valid_o !== expValid || done_o !== expDone) begin
          errors++;
          $display("[TB] FAIL random_flags frame %0d cyc %0d: got valid=%b done=%b, want valid=%b done=%b", f, k, valid_o, done_o, expValid, expDone);
        end
        if (expValid) begin
          checks++;
          if (window_o !== expWin) begin
            errors++;
            $display("[TB] FAIL random_window frame %0d cyc %0d: got %h, want %h", f, k, window_o, expWin);
          end
        end
        if (valid_o === 1'b1) nWin++;
        if (done_o === 1'b1) nDone++;
      end
      checks++;
      if (nWin != (IW - 2) * (IH - 2) || nDone != 1) begin
        errors++;
        $display("[TB] FAIL random_count frame %0d: got %0d windows %0d done, want %0d and 1", f, nWin, nDone, (IW - 2) * (IH - 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gaps();
    test_after_done();
    test_reset_midframe();
    test_start_with_valid();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
